i2s_audio_tx_stream: RTL and testbench
======================================

Name: i2s_audio_tx_stream

Overview:
Parametrised successor to the fixed-format mono I2S output. It serialises stereo or mono PCM samples onto an I2S or left-justified bus. The bus carries MCLK/BCLK/LRCLK/SDATA, all generated from the system clock by integer dividers. Samples arrive over a valid/ready handshake into a one-frame holding register, with defined underrun behaviour. The block sits between lab audio generators (tone, sample player) and the GPIO pins of any board_specific_top.

Parameters:
w_sample, 16, PCM sample width in bits, 2..w_slot
w_slot, 32, BCLK periods per channel slot, 8..64
bclk_half, 7, clk cycles per BCLK half-period, >=1 (27 MHz gives 1.93 MHz BCLK and fs 30.1 kHz)
mclk_half, 1, clk cycles per MCLK half-period, >=1
n_channels, 2, 1 = mono (sample_l is duplicated into both slots), 2 = stereo
format, I2S_PHILIPS, I2S_PHILIPS or LEFT_JUSTIFIED
underrun_repeat, 0, 0 = send zeros on underrun, 1 = repeat the last frame

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
sample_l  in  w_sample  left sample, two's complement
sample_r  in  w_sample  right sample; ignored when n_channels=1
valid  in  1  sample pair offered
ready  out  1  holding register empty
mclk  out  1  master clock
bclk  out  1  bit clock
lrclk  out  1  word select (0 = left slot)
sdata  out  1  serial data, MSB first
underrun  out  1  one-clk pulse when a frame starts with the holding register empty

Behaviour:
- Reset values: mclk=0, bclk=0, lrclk=0, sdata=0, ready=1, underrun=0. Holding register is empty and shift data is zero. Bit index b = 2*w_slot-1.
- MCLK: a free-running counter toggles mclk every mclk_half clk cycles. It is independent of BCLK phase.
- BCLK: a counter from 0 to bclk_half-1 toggles bclk on wrap.
  - "fall event" = wrap while bclk=1.
  - First rise comes bclk_half cycles after reset release; first fall comes at 2*bclk_half.
- Each fall event: b advances modulo 2*w_slot. lrclk and sdata update on the same clk edge as bclk falls. Receivers sample on the BCLK rise.
- Left-justified stream value for bit b, with slot k=b/w_slot and j=b%w_slot:
  - j<w_sample: sample_k[w_sample-1-j]
  - otherwise: 0
- lrclk = (b>=w_slot).
- LEFT_JUSTIFIED: sdata = stream(b).
- I2S_PHILIPS: sdata = stream(b-1 mod 2*w_slot), i.e. the stream delayed one BCLK period through a one-bit register. lrclk is not delayed, so it switches one bit before the MSB. With w_sample=w_slot, bit 0 carries the previous frame's right LSB.
- Frame load happens on the fall event that takes b to 0:
  - Holding full: copy the holding register to the frame register and clear full.
  - Holding empty: pulse underrun for 1 clk. The frame register gets zeros (underrun_repeat=0) or is unchanged (underrun_repeat=1).
- Handshake:
  - ready = !full, registered. Accept when valid && ready; full sets on the next edge.
  - ready is low while full, so a load and an accept never share a cycle with a full register.
  - An accept in the same cycle as a load of an empty register stores into holding; that frame goes out next frame, and underrun still pulses.
- Inputs are stable only while valid is high. Data is captured at accept; later changes have no effect.
- Mono: the slot-1 data source is sample_l.
- Reset mid-frame returns everything to the reset values asynchronously. A pending holding sample is discarded.
- Elaboration check: w_sample<=w_slot and bclk_half>=1, otherwise $error.

Decomposition:
- Package i2s_pkg holds typedef enum {I2S_PHILIPS, LEFT_JUSTIFIED} i2s_format_t and localparam function frame_clks(w_slot, bclk_half) = 4*w_slot*bclk_half.
- Sub-module i2s_clk_gen (mclk/bclk dividers, fall-event strobe, bit index b).
- The serialiser and handshake stay in the top module.

Test Plan:
- Reset and clocks, bclk_half=2, mclk_half=1: outputs at reset values; mclk period 2 clk; bclk period 4 clk with first fall at clk 4; lrclk period 256 clk.
- LEFT_JUSTIFIED with sample_l=16'hA5C3, sample_r=16'h8001 accepted before the first frame:
  - the 16 BCLK rises after lrclk falls read A5C3 MSB-first, then 16 zeros;
  - after lrclk rises they read 8001, then zeros;
  - ready returns to 1 at frame start.
- I2S_PHILIPS with the same data: sdata equals the LJ sequence delayed one BCLK; the lrclk fall precedes the MSB 'A' bit by exactly one BCLK.
- Underrun:
  - no valid for one frame: underrun pulses once per frame start, sdata stays 0;
  - rerun with underrun_repeat=1 after one frame of 1234/5678: the same bits repeat each frame.
- Mono (n_channels=1), sample_l=16'h7FFF, sample_r=16'h0000: both slots carry 7FFF.
- Reset mid-frame with rst asserted at b=20, holding full: all outputs are at reset values immediately; after release the first frame starts at clk 2*bclk_half and underruns.

Source files
------------

// File: rtl/i2s_audio_tx_stream_pkg.sv
// i2s_pkg: definitions shared by the I2S / left-justified serial audio transmitter.
//   i2s_format_t : bus framing selection.
//   frame_clks() : number of system clocks in one stereo frame (two slots).
package i2s_pkg;

   typedef enum logic {
      I2S_PHILIPS    = 1'b0,
      LEFT_JUSTIFIED = 1'b1
   } i2s_format_t;

   // One frame is 2 slots * w_slot bits * 2 BCLK half-periods * bclk_half clocks.
   function automatic int frame_clks(input int w_slot, input int bclk_half);
      return 4 * w_slot * bclk_half;
   endfunction

endpackage

// File: rtl/i2s_audio_tx_stream_clk_gen.sv
// i2s_clk_gen: clock dividers and bit sequencing for the audio transmitter.
//   clk, rst   : system clock, asynchronous active-high reset
//   mclk_o     : master clock, toggles every mclk_half clocks, free running
//   bclk_o     : bit clock, toggles every bclk_half clocks
//   fall_o     : strobe, high in the clock cycle whose edge drives bclk low
//   b_next_o   : bit index in the frame as it will be after this edge
//                (advances only on fall_o, modulo 2*w_slot)
module i2s_clk_gen
   import i2s_pkg::*;
#(
   parameter int w_slot    = 32,
   parameter int bclk_half = 7,
   parameter int mclk_half = 1,
   parameter int BW        = $clog2(2 * w_slot)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          mclk_o,
   output logic          bclk_o,
   output logic          fall_o,
   output logic [BW-1:0] b_next_o
);

   localparam int MCW = (mclk_half > 1) ? $clog2(mclk_half) : 1;
   localparam int BCW = (bclk_half > 1) ? $clog2(bclk_half) : 1;
   localparam logic [MCW-1:0] MC_LAST = MCW'(mclk_half - 1);
   localparam logic [BCW-1:0] BC_LAST = BCW'(bclk_half - 1);
   localparam logic [BW-1:0]  B_LAST  = BW'(2 * w_slot - 1);

   logic [MCW-1:0] mcnt_q, mcnt_d;
   logic [BCW-1:0] bcnt_q, bcnt_d;
   logic           mclk_q, mclk_d;
   logic           bclk_q, bclk_d;
   logic [BW-1:0]  b_q, b_d;
   logic           bwrap;
   logic           fall;

   always_comb begin
      mcnt_d = mcnt_q + 1'b1;
      mclk_d = mclk_q;
      if (mcnt_q == MC_LAST) begin
         mcnt_d = '0;
         mclk_d = ~mclk_q;
      end

      bcnt_d = bcnt_q + 1'b1;
      bclk_d = bclk_q;
      bwrap  = (bcnt_q == BC_LAST);
      if (bwrap) begin
         bcnt_d = '0;
         bclk_d = ~bclk_q;
      end

      // A wrap while bclk is high is the edge that takes bclk low.
      fall = bwrap && bclk_q;
      b_d  = b_q;
      if (fall) begin
         b_d = (b_q == B_LAST) ? '0 : b_q + 1'b1;
      end
   end

   // The reset index is the last bit, so the first fall starts frame 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcnt_q <= '0;
         bcnt_q <= '0;
         mclk_q <= 1'b0;
         bclk_q <= 1'b0;
         b_q    <= B_LAST;
      end else begin
         mcnt_q <= mcnt_d;
         bcnt_q <= bcnt_d;
         mclk_q <= mclk_d;
         bclk_q <= bclk_d;
         b_q    <= b_d;
      end
   end

   assign mclk_o   = mclk_q;
   assign bclk_o   = bclk_q;
   assign fall_o   = fall;
   assign b_next_o = b_d;

endmodule

// File: rtl/i2s_audio_tx_stream.sv
// i2s_audio_tx_stream: serialises stereo or mono PCM samples onto an I2S
// (Philips) or left-justified bus, with a one-frame holding register fed by a
// valid/ready handshake.
//   clk, rst           : system clock, asynchronous active-high reset
//   sample_l, sample_r : two's complement samples (sample_r unused in mono)
//   valid, ready       : handshake; ready is high while the holding register is empty
//   mclk, bclk, lrclk  : master clock, bit clock, word select (0 = left slot)
//   sdata              : serial data, MSB first, changes with bclk falling
//   underrun           : one-clock pulse when a frame starts with nothing held
module i2s_audio_tx_stream
   import i2s_pkg::*;
#(
   parameter int          w_sample        = 16,
   parameter int          w_slot          = 32,
   parameter int          bclk_half       = 7,
   parameter int          mclk_half       = 1,
   parameter int          n_channels      = 2,
   parameter i2s_format_t format          = I2S_PHILIPS,
   parameter int          underrun_repeat = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [w_sample-1:0] sample_l,
   input  logic [w_sample-1:0] sample_r,
   input  logic                valid,
   output logic                ready,
   output logic                mclk,
   output logic                bclk,
   output logic                lrclk,
   output logic                sdata,
   output logic                underrun
);

   localparam int BW = $clog2(2 * w_slot);
   localparam logic [BW-1:0] SLOT1_START = BW'(w_slot);

   if (w_sample > w_slot || w_sample < 2 || bclk_half < 1 || mclk_half < 1) begin : g_bad_params
      $error("i2s_audio_tx_stream: need 2 <= w_sample <= w_slot, bclk_half >= 1, mclk_half >= 1");
   end

   logic          fall;
   logic [BW-1:0] b_next;

   i2s_clk_gen #(
      .w_slot    (w_slot),
      .bclk_half (bclk_half),
      .mclk_half (mclk_half),
      .BW        (BW)
   ) u_clk_gen (
      .clk      (clk),
      .rst      (rst),
      .mclk_o   (mclk),
      .bclk_o   (bclk),
      .fall_o   (fall),
      .b_next_o (b_next)
   );

   logic [w_sample-1:0] hold_l_q, hold_l_d;
   logic [w_sample-1:0] hold_r_q, hold_r_d;
   logic                full_q, full_d;
   logic [w_sample-1:0] frame_l_q, frame_l_d;
   logic [w_sample-1:0] frame_r_q, frame_r_d;
   logic                lrclk_q, lrclk_d;
   logic                sdata_q, sdata_d;
   logic                dly_q, dly_d;
   logic                underrun_q, underrun_d;
   logic                accept;
   logic                load;
   logic                bit_next;

   // Left-justified stream bit for index b of the given frame: each slot
   // carries its sample MSB first, padded with zeros to w_slot bits.
   function automatic logic stream_bit(input logic [w_sample-1:0] l,
                                       input logic [w_sample-1:0] r,
                                       input logic [BW-1:0]       b);
      int                  j;
      logic [w_sample-1:0] s;
      j = int'(b);
      s = l;
      if (j >= w_slot) begin
         j = j - w_slot;
         s = r;
      end
      stream_bit = 1'b0;
      if (j < w_sample) begin
         s          = s << j;
         stream_bit = s[w_sample-1];
      end
   endfunction

   always_comb begin
      accept     = valid && !full_q;
      load       = fall && (b_next == '0);
      hold_l_d   = hold_l_q;
      hold_r_d   = hold_r_q;
      full_d     = full_q;
      frame_l_d  = frame_l_q;
      frame_r_d  = frame_r_q;
      underrun_d = 1'b0;
      lrclk_d    = lrclk_q;
      sdata_d    = sdata_q;
      dly_d      = dly_q;

      if (load) begin
         if (full_q) begin
            frame_l_d = hold_l_q;
            frame_r_d = hold_r_q;
            full_d    = 1'b0;
         end else begin
            underrun_d = 1'b1;
            if (underrun_repeat == 0) begin
               frame_l_d = '0;
               frame_r_d = '0;
            end
         end
      end

      // ready is low while full, so an accept never collides with a load
      // that empties the register; an accept beside an underrun load simply
      // fills the holding register for the following frame.
      if (accept) begin
         hold_l_d = sample_l;
         hold_r_d = (n_channels == 1) ? sample_l : sample_r;
         full_d   = 1'b1;
      end

      // The bit for the new index must see the frame loaded on this same edge.
      bit_next = stream_bit(frame_l_d, frame_r_d, b_next);
      if (fall) begin
         lrclk_d = (b_next >= SLOT1_START);
         dly_d   = bit_next;
         // Philips framing emits the stream one bit late; lrclk is not delayed.
         sdata_d = (format == LEFT_JUSTIFIED) ? bit_next : dly_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_l_q   <= '0;
         hold_r_q   <= '0;
         full_q     <= 1'b0;
         frame_l_q  <= '0;
         frame_r_q  <= '0;
         lrclk_q    <= 1'b0;
         sdata_q    <= 1'b0;
         dly_q      <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         hold_l_q   <= hold_l_d;
         hold_r_q   <= hold_r_d;
         full_q     <= full_d;
         frame_l_q  <= frame_l_d;
         frame_r_q  <= frame_r_d;
         lrclk_q    <= lrclk_d;
         sdata_q    <= sdata_d;
         dly_q      <= dly_d;
         underrun_q <= underrun_d;
      end
   end

   assign ready    = !full_q;
   assign lrclk    = lrclk_q;
   assign sdata    = sdata_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_audio_tx_stream.sv
// Bench for i2s_audio_tx_stream: four instances (LJ, Philips, LJ with frame
// repeat, LJ mono) run in lock-step from one clock and reset. A monitor
// records (lrclk, sdata) at every bclk rise; a frame-level reference model
// built from the bus rules predicts the bit sequences.
module tb_i2s_audio_tx_stream;
   import i2s_pkg::*;

   localparam int NG  = 4;
   localparam int NF  = 6;
   localparam int FR  = frame_clks(32, 2);
   localparam int FB  = 64;
   localparam int T0  = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [15:0]     sl [NG];
   logic [15:0]     sr [NG];
   logic [NG-1:0]   vld;
   logic [NG-1:0]   rdy, mclk_w, bclk_w, lrclk_w, sdata_w, underrun_w;

   int              cyc;
   int              n_tests = 0;
   int              n_fail  = 0;
   bit              rx_sd [NG][$];
   bit              rx_lr [NG][$];
   int              urn [NG];
   logic [NG-1:0]   pb;

   bit              has [NG][NF];
   logic [15:0]     dl [NG][NF];
   logic [15:0]     dr [NG][NF];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NG; g++) begin : g_dut
      i2s_audio_tx_stream #(
         .w_sample        (16),
         .w_slot          (32),
         .bclk_half       (2),
         .mclk_half       ((g == 3) ? 2 : 1),
         .n_channels      ((g == 3) ? 1 : 2),
         .format          ((g == 1) ? I2S_PHILIPS : LEFT_JUSTIFIED),
         .underrun_repeat ((g == 2) ? 1 : 0)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .sample_l (sl[g]),
         .sample_r (sr[g]),
         .valid    (vld[g]),
         .ready    (rdy[g]),
         .mclk     (mclk_w[g]),
         .bclk     (bclk_w[g]),
         .lrclk    (lrclk_w[g]),
         .sdata    (sdata_w[g]),
         .underrun (underrun_w[g])
      );
   end

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (rst) begin
         pb <= '0;
         for (int g = 0; g < NG; g++) begin
            rx_sd[g].delete();
            rx_lr[g].delete();
            urn[g] <= 0;
         end
      end else begin
         pb <= bclk_w;
         for (int g = 0; g < NG; g++) begin
            if (bclk_w[g] && !pb[g]) begin
               rx_sd[g].push_back(sdata_w[g]);
               rx_lr[g].push_back(lrclk_w[g]);
            end
            if (underrun_w[g]) urn[g] <= urn[g] + 1;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic to_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   function automatic int mh(input int g);
      return (g == 3) ? 2 : 1;
   endfunction

   // Reference left-justified frame: bit b of the result is the bit sent at index b.
   function automatic logic [63:0] lj_frame(input logic [15:0] l, input logic [15:0] r);
      logic [63:0] v;
      v = '0;
      for (int j = 0; j < 16; j++) begin
         v[j]      = l[15 - j];
         v[32 + j] = r[15 - j];
      end
      return v;
   endfunction

   task automatic offer(input int f);
      for (int g = 0; g < NG; g++) begin
         if (has[g][f]) begin
            vld[g] = 1'b1;
            sl[g]  = dl[g][f];
            sr[g]  = dr[g][f];
         end
      end
      @(negedge clk);
      for (int g = 0; g < NG; g++) begin
         if (has[g][f]) check($sformatf("ready low after accept g%0d f%0d", g, f), 64'(rdy[g]), 64'd0);
         vld[g] = 1'b0;
         sl[g]  = 16'($urandom);
         sr[g]  = 16'($urandom);
      end
   endtask

   initial begin
      logic [15:0] cl, cr;
      logic [63:0] ef, prev, obs_sd, obs_lr, exp_sd;
      int          n_under;

      vld = '0;
      for (int g = 0; g < NG; g++) begin
         sl[g] = '0;
         sr[g] = '0;
         for (int f = 0; f < NF; f++) begin
            has[g][f] = 1'b1;
            dl[g][f]  = 16'($urandom);
            dr[g][f]  = 16'($urandom);
         end
      end
      has[0][2] = 1'b0;
      has[1][3] = 1'b0;
      for (int f = 1; f < NF; f++) has[2][f] = 1'b0;
      dl[0][0] = 16'hA5C3; dr[0][0] = 16'h8001;
      dl[1][0] = 16'hA5C3; dr[1][0] = 16'h8001;
      dl[2][0] = 16'h1234; dr[2][0] = 16'h5678;
      dl[3][0] = 16'h7FFF; dr[3][0] = 16'h0000;

      repeat (3) @(negedge clk);
      for (int g = 0; g < NG; g++)
         check($sformatf("reset outputs g%0d", g),
               64'({mclk_w[g], bclk_w[g], lrclk_w[g], sdata_w[g], rdy[g], underrun_w[g]}), 64'b000010);
      rst = 1'b0;

      offer(0);
      for (int c = 1; c <= 3; c++) begin
         to_cyc(c);
         for (int g = 0; g < NG; g++) begin
            check($sformatf("mclk g%0d c%0d", g, c), 64'(mclk_w[g]), 64'((c / mh(g)) % 2));
            check($sformatf("bclk g%0d c%0d", g, c), 64'(bclk_w[g]), 64'((c / 2) % 2));
         end
      end

      for (int f = 0; f < NF; f++) begin
         to_cyc(T0 + FR * f - 1);
         for (int g = 0; g < NG; g++)
            if (has[g][f]) check($sformatf("ready held g%0d f%0d", g, f), 64'(rdy[g]), 64'd0);
         to_cyc(T0 + FR * f);
         for (int g = 0; g < NG; g++) begin
            check($sformatf("ready at frame start g%0d f%0d", g, f), 64'(rdy[g]), 64'd1);
            check($sformatf("underrun at frame start g%0d f%0d", g, f), 64'(underrun_w[g]), 64'(!has[g][f]));
            check($sformatf("bclk/lrclk at frame start g%0d f%0d", g, f),
                  64'({bclk_w[g], lrclk_w[g]}), 64'd0);
         end
         to_cyc(T0 + FR * f + 1);
         for (int g = 0; g < NG; g++)
            check($sformatf("underrun width g%0d f%0d", g, f), 64'(underrun_w[g]), 64'd0);
         if (f + 1 < NF) begin
            to_cyc(T0 + FR * f + 50);
            offer(f + 1);
         end
      end

      to_cyc(T0 + FR * NF - 1);
      for (int g = 0; g < NG; g++) begin
         cl = '0; cr = '0; prev = '0; n_under = 0;
         check($sformatf("bclk rise count g%0d", g), 64'(rx_sd[g].size()), 64'(1 + FB * NF));
         check($sformatf("pre-frame bit g%0d", g), 64'({rx_lr[g][0], rx_sd[g][0]}), 64'd0);
         for (int f = 0; f < NF; f++) begin
            if (has[g][f]) begin
               cl = dl[g][f];
               cr = (g == 3) ? dl[g][f] : dr[g][f];
            end else begin
               n_under++;
               if (g != 2) begin
                  cl = '0;
                  cr = '0;
               end
            end
            ef = lj_frame(cl, cr);
            for (int b = 0; b < FB; b++) begin
               obs_sd[b] = rx_sd[g][1 + FB * f + b];
               obs_lr[b] = rx_lr[g][1 + FB * f + b];
            end
            exp_sd = (g == 1) ? {ef[62:0], prev[63]} : ef;
            check($sformatf("sdata bits g%0d f%0d", g, f), obs_sd, exp_sd);
            check($sformatf("lrclk bits g%0d f%0d", g, f), obs_lr, 64'hFFFF_FFFF_0000_0000);
            prev = ef;
         end
         check($sformatf("underrun count g%0d", g), 64'(urn[g]), 64'(n_under));
      end

      // Mid-frame reset with a sample waiting in the holding register.
      to_cyc(T0 + FR * NF + 10);
      vld[0] = 1'b1;
      sl[0]  = 16'($urandom);
      sr[0]  = 16'($urandom);
      @(negedge clk);
      vld[0] = 1'b0;
      check("ready low before reset", 64'(rdy[0]), 64'd0);
      to_cyc(T0 + FR * NF + 82);
      check("holding full at b=20", 64'(rdy[0]), 64'd0);
      #1 rst = 1'b1;
      #1;
      for (int g = 0; g < NG; g++)
         check($sformatf("async reset outputs g%0d", g),
               64'({mclk_w[g], bclk_w[g], lrclk_w[g], sdata_w[g], rdy[g], underrun_w[g]}), 64'b000010);
      @(negedge clk);
      rst = 1'b0;
      to_cyc(T0 - 1);
      for (int g = 0; g < NG; g++)
         check($sformatf("post-reset before frame g%0d", g), 64'({bclk_w[g], underrun_w[g]}), 64'b10);
      to_cyc(T0);
      for (int g = 0; g < NG; g++)
         check($sformatf("post-reset frame start g%0d", g),
               64'({bclk_w[g], underrun_w[g], rdy[g], sdata_w[g]}), 64'b0110);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
